// File: rtl/spi_slave_rx.sv
// SPI receive-only slave, mode 0 (sclk idle low, sample on rising sclk).
// All SPI pins are oversampled on clk; sclk is treated as data, never as a clock.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a synchronized cs falling edge
// SHIFT   | frame in progress; shifting mosi on sclk rise until cs rise
module spi_slave_rx #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              mosi,
  input  logic              cs,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              busy,
  output logic              frame_err,
  output logic              overrun
);

  localparam int CNT_W = $clog2(DATA_W + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_OVER = CNT_W'(DATA_W + 1);

  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

  state_t state_q, state_d;

  logic sclk_m, sclk_s, sclk_h;
  logic mosi_m, mosi_s;
  logic cs_m, cs_s, cs_h;
  logic [1:0] rst_dly;
  logic armed;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [DATA_W-1:0] data_d;
  logic valid_d, ferr_d, ovr_d;

  logic sclk_rise, cs_fall, cs_rise;

  // Synchronize the SPI pins and keep one-cycle history for edge detection.
  // After reset, cs falls are ignored until the synchronizer holds a real
  // high level, so a cs already low when reset releases never opens a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_m  <= 1'b0;
      sclk_s  <= 1'b0;
      sclk_h  <= 1'b0;
      mosi_m  <= 1'b0;
      mosi_s  <= 1'b0;
      cs_m    <= 1'b1;
      cs_s    <= 1'b1;
      cs_h    <= 1'b1;
      rst_dly <= 2'b00;
      armed   <= 1'b0;
    end else begin
      sclk_m  <= sclk;
      sclk_s  <= sclk_m;
      sclk_h  <= sclk_s;
      mosi_m  <= mosi;
      mosi_s  <= mosi_m;
      cs_m    <= cs;
      cs_s    <= cs_m;
      cs_h    <= cs_s;
      rst_dly <= {rst_dly[0], 1'b1};
      if (rst_dly[1] && cs_s) armed <= 1'b1;
    end
  end

  assign sclk_rise = sclk_s & ~sclk_h;
  assign cs_fall   = armed & ~cs_s & cs_h;
  assign cs_rise   = cs_s & ~cs_h;

  // State, bit counter, shift register and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      shreg_q   <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      rx_data   <= data_d;
      rx_valid  <= valid_d;
      frame_err <= ferr_d;
      overrun   <= ovr_d;
    end
  end

  // Next-state, shifting, frame-end commit and handshake logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    data_d  = rx_data;
    valid_d = rx_valid;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;

    if (rx_valid && rx_ready) valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
          shreg_d = '0;
        end
      end
      ST_SHIFT: begin
        // cs rise takes priority over a coincident sclk rise.
        if (cs_rise) begin
          state_d = ST_IDLE;
          if (cnt_q == CNT_FULL) begin
            if (!rx_valid || rx_ready) begin
              data_d  = shreg_q;
              valid_d = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
          end else begin
            ferr_d = 1'b1;
          end
        end else if (sclk_rise) begin
          if (cnt_q < CNT_FULL) begin
            shreg_d = {shreg_q[DATA_W-2:0], mosi_s};
            cnt_d   = cnt_q + CNT_W'(1);
          end else begin
            cnt_d = CNT_OVER;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy = (state_q == ST_SHIFT);

endmodule

// File: tb/tb_spi_slave_rx.sv
// Self-checking bench for spi_slave_rx: directed scenarios plus random frames,
// compared every cycle against a frame-level reference model.
module tb_spi_slave_rx;

  localparam int DATA_W = 16;

  logic clk, rst, sclk, mosi, cs, rx_ready;
  logic [DATA_W-1:0] rx_data;
  logic rx_valid, busy, frame_err, overrun;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic        exp_valid, exp_ferr, exp_ovr, exp_busy;
  logic [15:0] exp_data;
  logic [2:0]  cs_hist;
  int          pend_len;
  logic [31:0] pend_word;

  spi_slave_rx #(.DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .mosi(mosi), .cs(cs),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .busy(busy), .frame_err(frame_err), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clk cycle: update the model at the rising edge (a frame finishes
  // two edges after cs is first seen high at an edge), then check all
  // outputs at the falling edge.
  task automatic step();
    logic prev, fin, acc;
    @(posedge clk);
    exp_ferr = 1'b0;
    exp_ovr  = 1'b0;
    if (rst) begin
      exp_valid = 1'b0;
      exp_data  = '0;
      cs_hist   = 3'b111;
    end else begin
      prev    = cs_hist[2];
      cs_hist = {cs_hist[1:0], cs};
      fin     = cs_hist[2] && !prev;
      acc     = exp_valid && rx_ready;
      if (fin && pend_len == DATA_W) begin
        if (!exp_valid || rx_ready) begin
          exp_data  = pend_word[15:0];
          exp_valid = 1'b1;
        end else begin
          exp_ovr = 1'b1;
        end
      end else begin
        if (acc) exp_valid = 1'b0;
        if (fin) exp_ferr = 1'b1;
      end
    end
    exp_busy = !cs_hist[2];
    @(negedge clk);
    check("rx_valid",  rx_valid,  exp_valid);
    check("rx_data",   rx_data,   exp_data);
    check("frame_err", frame_err, exp_ferr);
    check("overrun",   overrun,   exp_ovr);
    check("busy",      busy,      exp_busy);
  endtask

  // Send n bits of word (MSB first), sclk toggling every clk. With tail set,
  // an extra sclk rise coincides with the cs rise and must not count.
  // cr >= 0 sets rx_ready just before the commit edge.
  task automatic send(input logic [31:0] word, input int n, input bit tail, input int cr);
    pend_word = word;
    pend_len  = n;
    cs = 1'b0;
    repeat (4) step();
    for (int i = 0; i < n; i++) begin
      mosi = word[n-1-i];
      sclk = 1'b0;
      step();
      sclk = 1'b1;
      step();
    end
    sclk = 1'b0;
    step();
    cs = 1'b1;
    if (tail) begin
      sclk = 1'b1;
      mosi = 1'($urandom);
    end
    step();
    step();
    if (cr >= 0) rx_ready = cr[0];
    step();
    sclk = 1'b0;
  endtask

  initial begin
    rst = 1'b1; sclk = 1'b0; mosi = 1'b0; cs = 1'b1; rx_ready = 1'b0;
    pend_len = 0; pend_word = '0;
    exp_valid = 1'b0; exp_data = '0; exp_ferr = 1'b0; exp_ovr = 1'b0;
    exp_busy = 1'b0; cs_hist = 3'b111;
    repeat (3) step();
    check("reset_data", rx_data, 32'h0);
    rst = 1'b0;
    repeat (5) step();

    // basic frame, consumer always ready
    rx_ready = 1'b1;
    send(32'hA5C3, 16, 1'b0, -1);
    check("a5c3_valid", rx_valid, 32'h1);
    check("a5c3_data",  rx_data,  32'hA5C3);
    step();
    check("a5c3_pulse", rx_valid, 32'h0);

    // overrun: second frame dropped while first word is held
    rx_ready = 1'b0;
    send(32'h1234, 16, 1'b0, -1);
    send(32'hFFFF, 16, 1'b0, -1);
    check("ovr_pulse", overrun,  32'h1);
    check("ovr_hold",  rx_data,  32'h1234);
    step();
    check("ovr_once",  overrun,  32'h0);
    rx_ready = 1'b1;
    step();
    check("ovr_drain", rx_valid, 32'h0);

    // accept and commit in the same cycle
    rx_ready = 1'b0;
    send(32'h00FF, 16, 1'b0, -1);
    send(32'hBEEF, 16, 1'b0, 1);
    check("same_data",  rx_data,  32'hBEEF);
    check("same_valid", rx_valid, 32'h1);
    check("same_ovr",   overrun,  32'h0);
    step();

    // short and long frames
    send(32'h1FFF, 15, 1'b0, -1);
    check("short_err", frame_err, 32'h1);
    send(32'h1ABCD, 17, 1'b0, -1);
    check("long_err",  frame_err, 32'h1);
    check("long_nov",  rx_valid,  32'h0);
    send(32'h8001, 16, 1'b0, -1);
    check("after_err", rx_data,   32'h8001);

    // coincident cs rise and sclk rise: extra bit ignored
    send(32'h6C3A, 16, 1'b1, -1);
    check("tail_data", rx_data,   32'h6C3A);
    check("tail_err",  frame_err, 32'h0);

    // reset after 8 bits of a frame
    cs = 1'b0;
    repeat (4) step();
    pend_len = 8;
    for (int i = 0; i < 8; i++) begin
      mosi = 1'($urandom);
      sclk = 1'b0;
      step();
      sclk = 1'b1;
      step();
    end
    sclk = 1'b0;
    rst = 1'b1;
    step();
    cs = 1'b1;
    step();
    check("rst_busy", busy, 32'h0);
    rst = 1'b0;
    repeat (6) step();
    send(32'h5A5A, 16, 1'b0, -1);
    check("post_rst", rx_data, 32'h5A5A);

    // sclk activity with cs high is ignored
    for (int i = 0; i < 10; i++) begin
      sclk = ~sclk;
      mosi = 1'($urandom);
      step();
    end
    sclk = 1'b0;
    step();

    // random frames with random lengths, handshakes and gaps
    for (int f = 0; f < 40; f++) begin
      int n, gap, cr;
      case ($urandom_range(0, 5))
        0:       n = 15;
        1:       n = 17;
        default: n = 16;
      endcase
      gap = $urandom_range(1, 4);
      for (int g = 0; g < gap; g++) begin
        rx_ready = 1'($urandom);
        step();
      end
      cr = int'($urandom_range(0, 2)) - 1;
      send({15'h0, 17'($urandom)}, n, 1'($urandom), cr);
    end
    rx_ready = 1'b1;
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_slave_rx.md
SPI_SLAVE_RX -- requirements
Module: spi_slave_rx

Interface
REQ-001 Parameter: DATA_W, default 16, frame word width in bits.
REQ-002 clk  input  1  system clock; all logic is on its rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 sclk  input  1  SPI clock from the master (idle low); sampled as data, never used as a clock.
REQ-005 mosi  input  1  SPI serial data, MSB first.
REQ-006 cs  input  1  SPI chip select, active-low; a frame spans cs low to cs high.
REQ-007 rx_data  output  DATA_W  last committed word.
REQ-008 rx_valid  output  1  rx_data holds an unconsumed word.
REQ-009 rx_ready  input  1  consumer accepts rx_data when rx_valid and rx_ready are both high at a clk edge.
REQ-010 busy  output  1  a frame is in progress (synchronized cs low).
REQ-011 frame_err  output  1  one-cycle pulse: the frame ended with a bit count other than DATA_W.
REQ-012 overrun  output  1  one-cycle pulse: a good frame arrived while rx_valid was high and was not being accepted.

Function
REQ-013 sclk, mosi and cs SHALL each pass through an identical 2-flop synchronizer (sclk_s, mosi_s, cs_s), plus one history flop each for sclk_s and cs_s.
REQ-014 Edge detection: sclk rise = sclk_s high and history low; cs fall = cs_s low and history high; cs rise = cs_s high and history low.
REQ-015 States: IDLE and SHIFT.
REQ-016 IDLE -> SHIFT on cs fall; bit_cnt cleared to 0; shift register cleared.
REQ-017 In SHIFT, on each sclk rise the block SHALL shift mosi_s into the LSB of the shift register (left shift) and increment bit_cnt, saturating at DATA_W+1.
REQ-018 Bits beyond DATA_W SHALL NOT alter the shift register; bit_cnt saturates, marking the frame as too long.
REQ-019 SHIFT -> IDLE on cs rise.
REQ-020 If bit_cnt == DATA_W at the cs rise, the frame is good; otherwise frame_err SHALL pulse for exactly one cycle and no word is committed.
REQ-021 Good-frame commit, when rx_valid is low or rx_ready is high in the same cycle: rx_data is loaded with the shift register and rx_valid is set.
REQ-022 Good-frame commit when rx_valid is high and rx_ready is low: the new word is dropped, rx_data is held, and overrun pulses for one cycle.
REQ-023 Accept without a commit clears rx_valid on the next edge. A simultaneous accept and commit keeps rx_valid high and loads the new word, with no overrun.
REQ-024 Latency: rx_valid (or frame_err) SHALL register on the 2nd clk edge after the first edge that samples cs=1.
REQ-025 An sclk rise while in IDLE is ignored. A cs rise and an sclk rise in the same cycle: the cs rise wins and the bit is not counted.
REQ-026 Each sclk level must persist at least 1 clk cycle; the block SHALL then capture every bit of a master toggling sclk every clk cycle.
REQ-027 busy SHALL equal 1 exactly while the state is SHIFT.
REQ-028 rx_data SHALL stay stable while rx_valid is high and not accepted.

Reset
REQ-029 rst high at a clk edge SHALL force: state IDLE, bit_cnt 0, shift register 0, rx_data 0, rx_valid 0, busy 0, frame_err 0, overrun 0.
REQ-030 Synchronizer flops reset to the idle bus levels: sclk 0, mosi 0, cs 1, with histories matching, so no spurious edge follows reset.
REQ-031 Reset mid-frame SHALL discard the partial word and raise no frame_err. A frame whose cs fall preceded reset release is ignored until the next cs fall.

Verification
REQ-032 Send 16 bits 0xA5C3 (sclk toggling every clk), rx_ready=1 -> rx_valid pulses one cycle with rx_data=0xA5C3, no error flags.
REQ-033 Send 0x1234 with rx_ready=0, then 0xFFFF -> rx_data stays 0x1234, rx_valid stays high, overrun pulses once; raising rx_ready clears rx_valid the next cycle.
REQ-034 Send 0x00FF, then assert rx_ready in the same cycle that 0xBEEF commits -> rx_data=0xBEEF, rx_valid high, overrun=0.
REQ-035 Frames of 15 bits and of 17 bits -> frame_err pulses once each, rx_valid stays 0, and the next 16-bit frame 0x8001 is received correctly.
REQ-036 Assert rst after 8 bits of a frame -> all outputs 0, no frame_err; a following full frame 0x5A5A is received correctly.
REQ-037 sclk pulses with cs high -> no state change, busy=0, no outputs.
